// File: rtl/writeback_unit.sv
// writeback_unit
//   Write-side initiator for the 16x16 register file. ALU results and
//   buffered load results share the file's single write port. ALU results
//   have priority. Loads wait in a small FIFO until a cycle with no ALU
//   result. A pending-write scoreboard tells the issue logic which
//   registers still have a write outstanding.
//
// Ports
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   issue_valid/dst instruction issuing with destination register
//   alu_valid/dst/data   ALU result (always accepted)
//   mem_valid/dst/data   load result, accepted when mem_ready
//   mem_ready       FIFO has room (depends on state only)
//   DstReg/WriteReg/DstData  register file write port (registered)
//   pending         bit i set = write to Ri outstanding
//   fifo_count      load FIFO occupancy
module writeback_unit #(
    parameter int unsigned DEPTH   = 2,
    parameter bit          R0_ZERO = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        issue_valid,
    input  logic [3:0]  issue_dst,
    input  logic        alu_valid,
    input  logic [3:0]  alu_dst,
    input  logic [15:0] alu_data,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [3:0]  mem_dst,
    input  logic [15:0] mem_data,
    output logic [3:0]  DstReg,
    output logic        WriteReg,
    output logic [15:0] DstData,
    output logic [15:0] pending,
    output logic [1:0]  fifo_count
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [3:0]    fifoDst  [DEPTH];
    logic [15:0]   fifoData [DEPTH];
    logic [PW-1:0] wrPtr;
    logic [PW-1:0] rdPtr;
    logic [CW-1:0] count;

    logic          push;
    logic          pop;
    logic [3:0]    selDst;
    logic [15:0]   selData;
    logic          selValid;
    logic [15:0]   pendingNext;

    assign mem_ready  = (count != FULL);
    assign fifo_count = 2'(count);

    // Pop uses the pre-edge count, so a load pushed this edge can never be
    // popped on the same edge.
    assign push = mem_valid & mem_ready;
    assign pop  = !alu_valid && (count != '0);

    // Payload storage needs no reset; occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifoDst[wrPtr]  <= mem_dst;
            fifoData[wrPtr] <= mem_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + PW'(1);
            if (pop)  rdPtr <= rdPtr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Output arbitration: ALU first, then FIFO head.
    always_comb begin
        selValid = 1'b0;
        selDst   = DstReg;
        selData  = DstData;
        if (alu_valid) begin
            selValid = 1'b1;
            selDst   = alu_dst;
            selData  = alu_data;
        end else if (pop) begin
            selValid = 1'b1;
            selDst   = fifoDst[rdPtr];
            selData  = fifoData[rdPtr];
        end
    end

    // A result for R0 still occupies its slot but never raises the enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            WriteReg <= 1'b0;
            DstReg   <= '0;
            DstData  <= '0;
        end else begin
            WriteReg <= selValid && !(R0_ZERO && (selDst == 4'd0));
            DstReg   <= selDst;
            DstData  <= selData;
        end
    end

    // Clear first, then set, so a new producer to the register being
    // written this edge keeps its pending bit.
    always_comb begin
        pendingNext = pending;
        if (WriteReg) pendingNext[DstReg] = 1'b0;
        if (issue_valid && !(R0_ZERO && (issue_dst == 4'd0)))
            pendingNext[issue_dst] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pending <= '0;
        else     pending <= pendingNext;
    end

endmodule

// File: tb/tb_writeback_unit.sv
module tb_writeback_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        issue_valid = 1'b0;
    logic [3:0]  issue_dst = '0;
    logic        alu_valid = 1'b0;
    logic [3:0]  alu_dst = '0;
    logic [15:0] alu_data = '0;
    logic        mem_valid = 1'b0;
    logic        mem_ready;
    logic [3:0]  mem_dst = '0;
    logic [15:0] mem_data = '0;
    logic [3:0]  DstReg;
    logic        WriteReg;
    logic [15:0] DstData;
    logic [15:0] pending;
    logic [1:0]  fifo_count;

    int checks = 0;
    int errors = 0;

    writeback_unit #(.DEPTH(2), .R0_ZERO(1'b1)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_dst(issue_dst),
        .alu_valid(alu_valid), .alu_dst(alu_dst), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_dst(mem_dst), .mem_data(mem_data),
        .DstReg(DstReg), .WriteReg(WriteReg), .DstData(DstData),
        .pending(pending), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [3:0]  idst;
        logic        av;
        logic [3:0]  adst;
        logic [15:0] adata;
        logic        mv;
        logic [3:0]  mdst;
        logic [15:0] mdata;
        logic        eWr;
        logic [3:0]  eDst;
        logic [15:0] eData;
        logic [15:0] ePend;
        logic [1:0]  eCnt;
        logic        eRdy;
    } vec_t;

    vec_t vecs [20];

    function automatic vec_t mk(input logic iv, input logic [3:0] idst,
                                input logic av, input logic [3:0] adst, input logic [15:0] adata,
                                input logic mv, input logic [3:0] mdst, input logic [15:0] mdata,
                                input logic eWr, input logic [3:0] eDst, input logic [15:0] eData,
                                input logic [15:0] ePend, input logic [1:0] eCnt, input logic eRdy);
        vec_t v;
        v.iv = iv; v.idst = idst; v.av = av; v.adst = adst; v.adata = adata;
        v.mv = mv; v.mdst = mdst; v.mdata = mdata;
        v.eWr = eWr; v.eDst = eDst; v.eData = eData; v.ePend = ePend;
        v.eCnt = eCnt; v.eRdy = eRdy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic iv, input logic [3:0] idst,
                         input logic av, input logic [3:0] adst, input logic [15:0] adata,
                         input logic mv, input logic [3:0] mdst, input logic [15:0] mdata);
        issue_valid = iv; issue_dst = idst;
        alu_valid = av; alu_dst = adst; alu_data = adata;
        mem_valid = mv; mem_dst = mdst; mem_data = mdata;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chkPort(input string tag, input logic eWr, input logic [3:0] eDst,
                           input logic [15:0] eData, input logic [15:0] ePend,
                           input logic [1:0] eCnt, input logic eRdy);
        chk({tag, ".WriteReg"}, 16'(WriteReg), 16'(eWr));
        if (eWr) begin
            chk({tag, ".DstReg"},  16'(DstReg), 16'(eDst));
            chk({tag, ".DstData"}, DstData, eData);
        end
        chk({tag, ".pending"},    pending, ePend);
        chk({tag, ".fifo_count"}, 16'(fifo_count), 16'(eCnt));
        chk({tag, ".mem_ready"},  16'(mem_ready), 16'(eRdy));
    endtask

    initial begin
        // Single ALU result, load deferred by ALU, R0, same-register set/clear,
        // simultaneous push/pop. Expected values hold after the vector's edge.
        vecs[0]  = mk(1,3, 0,0,16'h0000, 0,0,16'h0000, 0,0,16'h0000, 16'h0008, 0, 1);
        vecs[1]  = mk(0,0, 0,0,16'h0000, 0,0,16'h0000, 0,0,16'h0000, 16'h0008, 0, 1);
        vecs[2]  = mk(0,0, 1,3,16'h1234, 0,0,16'h0000, 1,3,16'h1234, 16'h0008, 0, 1);
        vecs[3]  = mk(0,0, 0,0,16'h0000, 0,0,16'h0000, 0,3,16'h1234, 16'h0000, 0, 1);
        vecs[4]  = mk(1,5, 1,1,16'h0011, 1,5,16'hBEEF, 1,1,16'h0011, 16'h0020, 1, 1);
        vecs[5]  = mk(0,0, 1,2,16'h0022, 0,0,16'h0000, 1,2,16'h0022, 16'h0020, 1, 1);
        vecs[6]  = mk(0,0, 0,0,16'h0000, 0,0,16'h0000, 1,5,16'hBEEF, 16'h0020, 0, 1);
        vecs[7]  = mk(0,0, 0,0,16'h0000, 0,0,16'h0000, 0,5,16'hBEEF, 16'h0000, 0, 1);
        vecs[8]  = mk(1,0, 0,0,16'h0000, 0,0,16'h0000, 0,0,16'h0000, 16'h0000, 0, 1);
        vecs[9]  = mk(0,0, 1,0,16'hFFFF, 0,0,16'h0000, 0,0,16'h0000, 16'h0000, 0, 1);
        vecs[10] = mk(0,0, 0,0,16'h0000, 0,0,16'h0000, 0,0,16'h0000, 16'h0000, 0, 1);
        vecs[11] = mk(1,7, 0,0,16'h0000, 0,0,16'h0000, 0,0,16'h0000, 16'h0080, 0, 1);
        vecs[12] = mk(0,0, 1,7,16'h7777, 0,0,16'h0000, 1,7,16'h7777, 16'h0080, 0, 1);
        vecs[13] = mk(1,7, 0,0,16'h0000, 0,0,16'h0000, 0,0,16'h0000, 16'h0080, 0, 1);
        vecs[14] = mk(0,0, 1,7,16'h0707, 0,0,16'h0000, 1,7,16'h0707, 16'h0080, 0, 1);
        vecs[15] = mk(0,0, 0,0,16'h0000, 0,0,16'h0000, 0,0,16'h0000, 16'h0000, 0, 1);
        vecs[16] = mk(0,0, 1,8,16'h0008, 1,9,16'h0009, 1,8,16'h0008, 16'h0000, 1, 1);
        vecs[17] = mk(0,0, 0,0,16'h0000, 1,10,16'h000A, 1,9,16'h0009, 16'h0000, 1, 1);
        vecs[18] = mk(0,0, 0,0,16'h0000, 0,0,16'h0000, 1,10,16'h000A, 16'h0000, 0, 1);
        vecs[19] = mk(0,0, 0,0,16'h0000, 0,0,16'h0000, 0,0,16'h0000, 16'h0000, 0, 1);

        // Reset state
        #12;
        chk("reset.WriteReg",   16'(WriteReg), 16'h0);
        chk("reset.DstReg",     16'(DstReg), 16'h0);
        chk("reset.DstData",    DstData, 16'h0);
        chk("reset.pending",    pending, 16'h0);
        chk("reset.fifo_count", 16'(fifo_count), 16'h0);
        chk("reset.mem_ready",  16'(mem_ready), 16'h1);
        rst = 1'b0;
        cyc();

        for (int i = 0; i < 20; i++) begin
            drive(vecs[i].iv, vecs[i].idst, vecs[i].av, vecs[i].adst, vecs[i].adata,
                  vecs[i].mv, vecs[i].mdst, vecs[i].mdata);
            cyc();
            chkPort($sformatf("vec%0d", i), vecs[i].eWr, vecs[i].eDst, vecs[i].eData,
                    vecs[i].ePend, vecs[i].eCnt, vecs[i].eRdy);
        end

        // FIFO full backpressure: ALU busy, loads R1, R2, R4 offered back-to-back
        drive(0,0, 1,11,16'h00B0, 1,1,16'h0101);
        cyc(); chkPort("bp.acc1", 1,11,16'h00B0, 16'h0000, 1, 1);
        drive(0,0, 1,11,16'h00B1, 1,2,16'h0202);
        cyc(); chkPort("bp.acc2", 1,11,16'h00B1, 16'h0000, 2, 0);
        drive(0,0, 1,11,16'h00B2, 1,4,16'h0404);
        cyc(); chkPort("bp.hold", 1,11,16'h00B2, 16'h0000, 2, 0);
        drive(0,0, 0,0,16'h0000, 1,4,16'h0404);
        cyc(); chkPort("bp.popR1", 1,1,16'h0101, 16'h0000, 1, 1);
        cyc(); chkPort("bp.popR2", 1,2,16'h0202, 16'h0000, 1, 1);
        drive(0,0, 0,0,16'h0000, 0,0,16'h0000);
        cyc(); chkPort("bp.popR4", 1,4,16'h0404, 16'h0000, 0, 1);
        cyc(); chkPort("bp.idle",  0,0,16'h0000, 16'h0000, 0, 1);

        // Async reset mid-operation: fill FIFO and pending = 0x00F0
        drive(1,4, 1,12,16'h0C00, 1,4,16'h4444); cyc();
        drive(1,5, 1,12,16'h0C01, 1,5,16'h5555); cyc();
        drive(1,6, 1,12,16'h0C02, 0,0,16'h0000); cyc();
        drive(1,7, 1,12,16'h0C03, 0,0,16'h0000); cyc();
        drive(0,0, 0,0,16'h0000, 0,0,16'h0000);
        chkPort("ar.before", 1,12,16'h0C03, 16'h00F0, 2, 0);
        #2 rst = 1'b1;
        #1;
        chk("ar.WriteReg",   16'(WriteReg), 16'h0);
        chk("ar.DstReg",     16'(DstReg), 16'h0);
        chk("ar.DstData",    DstData, 16'h0);
        chk("ar.pending",    pending, 16'h0);
        chk("ar.fifo_count", 16'(fifo_count), 16'h0);
        chk("ar.mem_ready",  16'(mem_ready), 16'h1);
        #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chkPort($sformatf("ar.after%0d", i), 0,0,16'h0000, 16'h0000, 0, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
